// File: rtl/sdmac_pkg.sv
// Purpose: shared CNTR register constants for the SDMAC control block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sdmac_pkg;

  localparam int CNTR_W = 6;
  localparam logic [CNTR_W-1:0] CNTR_RST = 6'b000000;

  // CNTR bit positions
  localparam int CNTR_TCEN  = 5;
  localparam int CNTR_PREST = 4;
  localparam int CNTR_PDMD  = 3;
  localparam int CNTR_INTEN = 2;
  localparam int CNTR_DDIR  = 1;
  localparam int CNTR_IO_DX = 0;

endpackage

// File: rtl/sdmac_strobe_sync.sv
// Purpose: qualify host strobes into capture (wq), commit and read-select; optional 2-flop sync (CTRL_REG_SYNC_EN).
// Latency: commit 1 clock after _DS rises, 3 clocks with CTRL_REG_SYNC_EN; read select live or +2 clocks synced.
// Backpressure: none; the host strobe paces every transfer.
module sdmac_strobe_sync
  import sdmac_pkg::*;
#(
  parameter int W = CNTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena_n,
  input  logic         ds_n,
  input  logic         r_w,
  input  logic [W-1:0] din,
  output logic [W-1:0] din_q,
  output logic         wq,
  output logic         commit,
  output logic         rd_sel
);

  logic ena_s;
  logic ds_s;
  logic rw_s;
  logic pend;
  logic abort;

`ifdef CTRL_REG_SYNC_EN
  logic [1:0]   ena_sr;
  logic [1:0]   ds_sr;
  logic [1:0]   rw_sr;
  logic [W-1:0] din_s1;
  logic [W-1:0] din_s2;

  // Two-stage synchronizers; DIN is delayed identically so it stays aligned with the strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ena_sr <= 2'b11;
      ds_sr  <= 2'b11;
      rw_sr  <= 2'b11;
      din_s1 <= '0;
      din_s2 <= '0;
    end else begin
      ena_sr <= {ena_sr[0], ena_n};
      ds_sr  <= {ds_sr[0], ds_n};
      rw_sr  <= {rw_sr[0], r_w};
      din_s1 <= din;
      din_s2 <= din_s1;
    end
  end

  assign ena_s = ena_sr[1];
  assign ds_s  = ds_sr[1];
  assign rw_s  = rw_sr[1];
  assign din_q = din_s2;
`else
  assign ena_s = ena_n;
  assign ds_s  = ds_n;
  assign rw_s  = r_w;
  assign din_q = din;
`endif

  // pend is only set while _DS is low, so pend && _DS high marks the first high sample: the rising edge.
  assign wq     = !ena_s && !rw_s && !ds_s;
  assign commit = pend && ds_s;
  assign abort  = pend && !ds_s && (ena_s || rw_s);
  assign rd_sel = !ena_s && rw_s && !ds_s;

  // Pending-write flag: armed by a qualified write, cleared by commit, abort or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (wq) begin
      pend <= 1'b1;
    end else if (commit || abort) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sdmac_ctrl_reg.sv
// Purpose: SDMAC CNTR register; host write/read over strobed bus, bits driven to DMA/SCSI logic (CTRL_REG_SYNC_EN optional).
// Latency: outputs update on the commit edge (1 clock after _DS rises, 3 with CTRL_REG_SYNC_EN); DOUT combinational.
// Backpressure: none; the host strobe paces every transfer.
module sdmac_ctrl_reg
  import sdmac_pkg::*;
#(
  parameter int               WIDTH   = CNTR_W,
  parameter logic [WIDTH-1:0] RST_VAL = CNTR_RST
) (
  input  logic             SCLK,
  input  logic             _RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             _ENA,
  input  logic             _DS,
  input  logic             R_W,
  output logic [WIDTH-1:0] DOUT,
  output logic             TCEN,
  output logic             PREST,
  output logic             PDMD,
  output logic             INTEN,
  output logic             DDIR,
  output logic             IO_DX
);

  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] cntr;
  logic             wq;
  logic             commit;
  logic             rd_sel;

  sdmac_strobe_sync #(
    .W (WIDTH)
  ) u_strobe (
    .clk    (SCLK),
    .rst_n  (_RST),
    .ena_n  (_ENA),
    .ds_n   (_DS),
    .r_w    (R_W),
    .din    (DIN),
    .din_q  (din_q),
    .wq     (wq),
    .commit (commit),
    .rd_sel (rd_sel)
  );

  // Shadow capture while the write strobe is held; last sampled value wins.
  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      cap <= RST_VAL;
    end else if (wq) begin
      cap <= din_q;
    end
  end

  // Architectural register, loaded from the shadow only on strobe release.
  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      cntr <= RST_VAL;
    end else if (commit) begin
      cntr <= cap;
    end
  end

  // Read-back gating; zero whenever the register is not being read.
  always_comb begin
    DOUT = '0;
    if (rd_sel) begin
      DOUT = cntr;
    end
  end

  assign TCEN  = cntr[CNTR_TCEN];
  assign PREST = cntr[CNTR_PREST];
  assign PDMD  = cntr[CNTR_PDMD];
  assign INTEN = cntr[CNTR_INTEN];
  assign DDIR  = cntr[CNTR_DDIR];
  assign IO_DX = cntr[CNTR_IO_DX];

endmodule

// File: tb/tb_sdmac_ctrl_reg.sv
// Purpose: self-checking bench for sdmac_ctrl_reg; transaction-level reference model, directed then random traffic.
// Latency: expects commit 1 clock after _DS rises (3 with CTRL_REG_SYNC_EN), read data live (2 clocks synced).
// Backpressure: n/a.
module tb_sdmac_ctrl_reg;

`ifdef CTRL_REG_SYNC_EN
  localparam int WR_LAT = 3;
  localparam int RD_LAT = 2;
`else
  localparam int WR_LAT = 1;
  localparam int RD_LAT = 0;
`endif

  logic       SCLK = 1'b0;
  logic       _RST;
  logic [5:0] DIN;
  logic       _ENA;
  logic       _DS;
  logic       R_W;
  logic [5:0] DOUT;
  logic       TCEN, PREST, PDMD, INTEN, DDIR, IO_DX;

  logic [5:0] exp_reg;
  int         n_cmp = 0;
  int         n_bad = 0;

  sdmac_ctrl_reg dut (
    .SCLK  (SCLK),
    ._RST  (_RST),
    .DIN   (DIN),
    ._ENA  (_ENA),
    ._DS   (_DS),
    .R_W   (R_W),
    .DOUT  (DOUT),
    .TCEN  (TCEN),
    .PREST (PREST),
    .PDMD  (PDMD),
    .INTEN (INTEN),
    .DDIR  (DDIR),
    .IO_DX (IO_DX)
  );

  always #5 SCLK = ~SCLK;

  function automatic logic [5:0] bits();
    return {TCEN, PREST, PDMD, INTEN, DDIR, IO_DX};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  // Bus parked: register must hold its value and DOUT must read zero.
  task automatic idle(input int n);
    _ENA = 1'b1;
    _DS  = 1'b1;
    R_W  = 1'($urandom_range(1));
    DIN  = 6'($urandom);
    repeat (n) step();
    chk("idle_bits", bits(), exp_reg);
    chk("idle_dout", DOUT, 6'b000000);
  endtask

  // Full write strobe of n clocks; only the final DIN value should land.
  task automatic do_write(input logic [5:0] last, input int n);
    _ENA = 1'b0;
    R_W  = 1'b0;
    _DS  = 1'b0;
    for (int i = 0; i < n; i++) begin
      DIN = (i == n - 1) ? last : 6'($urandom);
      step();
    end
    chk("wr_pre", bits(), exp_reg);
    _DS = 1'b1;
    if ($urandom_range(1) == 1) _ENA = 1'b1;
    DIN = 6'($urandom);
    for (int i = 1; i <= WR_LAT; i++) begin
      step();
      if (i < WR_LAT) chk("wr_hold", bits(), exp_reg);
    end
    exp_reg = last;
    chk("wr_commit", bits(), exp_reg);
  endtask

  // Read strobe, then strobe released, then an unselected strobe.
  task automatic do_read(input logic [5:0] d);
    _ENA = 1'b0;
    R_W  = 1'b1;
    _DS  = 1'b0;
    DIN  = d;
    repeat (RD_LAT) step();
    #1;
    chk("rd_dout", DOUT, exp_reg);
    _DS = 1'b1;
    repeat (RD_LAT) step();
    #1;
    chk("rd_ds_hi", DOUT, 6'b000000);
    _ENA = 1'b1;
    _DS  = 1'b0;
    repeat (RD_LAT) step();
    #1;
    chk("rd_unsel", DOUT, 6'b000000);
    _DS = 1'b1;
  endtask

  // Write-direction strobe with the register deselected.
  task automatic do_unsel_write(input int n);
    _ENA = 1'b1;
    R_W  = 1'b0;
    _DS  = 1'b0;
    for (int i = 0; i < n; i++) begin
      DIN = 6'($urandom);
      step();
    end
    _DS = 1'b1;
    repeat (WR_LAT + 1) step();
    chk("unsel_wr", bits(), exp_reg);
  endtask

  // Select or direction drops while _DS is still low: the write must be discarded.
  task automatic do_abort(input logic [5:0] v, input int n);
    _ENA = 1'b0;
    R_W  = 1'b0;
    _DS  = 1'b0;
    DIN  = v;
    repeat (n) step();
    if ($urandom_range(1) == 1) _ENA = 1'b1;
    else R_W = 1'b1;
    repeat (3) step();
    chk("abort_hold", bits(), exp_reg);
    _DS = 1'b1;
    repeat (4) step();
    chk("abort_nocommit", bits(), exp_reg);
  endtask

  task automatic do_reset();
    _RST = 1'b0;
    step();
    _RST = 1'b1;
    exp_reg = 6'b000000;
    chk("rst_bits", bits(), exp_reg);
  endtask

  // Reset lands mid-strobe; the captured data must never commit.
  task automatic do_reset_mid(input logic [5:0] v, input int n);
    _ENA = 1'b0;
    R_W  = 1'b0;
    _DS  = 1'b0;
    DIN  = v;
    repeat (n) step();
    _RST = 1'b0;
    step();
    exp_reg = 6'b000000;
    chk("rst_mid", bits(), exp_reg);
    _RST = 1'b1;
    _ENA = 1'b1;
    repeat (3) step();
    _DS = 1'b1;
    repeat (4) step();
    chk("rst_nocommit", bits(), exp_reg);
  endtask

  initial begin
    _RST = 1'b0;
    _ENA = 1'b1;
    _DS  = 1'b1;
    R_W  = 1'b1;
    DIN  = 6'b000000;
    exp_reg = 6'b000000;
    repeat (3) step();
    chk("reset_bits", bits(), 6'b000000);
    chk("reset_dout", DOUT, 6'b000000);
    _RST = 1'b1;
    idle(3);

    do_write(6'b111111, 2);
    idle(3);
    do_reset();
    idle(3);
    do_read(6'b110011);
    idle(3);

    do_write(6'b010101, 3);
    chk("bit_prest", {5'b0, PREST}, 6'b000001);
    chk("bit_tcen", {5'b0, TCEN}, 6'b000000);
    idle(3);
    do_read(6'b101010);
    idle(3);
    do_unsel_write(2);
    idle(3);
    chk("hold_010101", bits(), 6'b010101);

    do_reset_mid(6'b111111, 2);
    idle(3);
    do_abort(6'b100000, 2);
    idle(3);
    chk("abort_tcen", {5'b0, TCEN}, 6'b000000);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(9))
        0, 1, 2, 3: do_write(6'($urandom), 1 + int'($urandom_range(3)));
        4, 5:       do_read(6'($urandom));
        6:          do_unsel_write(1 + int'($urandom_range(3)));
        7:          do_abort(6'($urandom), 1 + int'($urandom_range(3)));
        8:          do_reset_mid(6'($urandom), 1 + int'($urandom_range(3)));
        default:    do_reset();
      endcase
      idle(3 + int'($urandom_range(2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdmac_ctrl_reg.md
Name: sdmac_ctrl_reg

Overview:
6-bit CNTR (control) register of the SDMAC replacement, written and read by the host over the strobed register bus.
- Latches host data on a qualified write strobe.
- Exposes each control bit as a dedicated output to the DMA/SCSI logic.
- Drives the register contents onto the read-data bus during qualified reads.
- Sits behind the register address decoder, which supplies _ENA.

Parameters:
WIDTH, 6, register width; fixed at 6, other values unsupported.
RST_VAL, 6'b000000, value loaded on reset.

Ports:
SCLK  in  1  system clock; all state updates on rising edge.
_RST  in  1  reset, synchronous, active-low.
DIN  in  6  write data from host data bus.
_ENA  in  1  active-low register select from address decoder.
_DS  in  1  active-low data strobe.
R_W  in  1  1 = read, 0 = write.
DOUT  out  6  read-back data.
TCEN  out  1  terminal-count enable (bit 5).
PREST  out  1  peripheral reset (bit 4).
PDMD  out  1  peripheral device mode DMA (bit 3).
INTEN  out  1  interrupt enable (bit 2).
DDIR  out  1  DMA direction (bit 1).
IO_DX  out  1  I/O data transfer (bit 0).

Behaviour:
- One clock (SCLK); reset is synchronous and active-low (_RST).
- Reset:
  - On a rising SCLK edge with _RST=0, register <= RST_VAL (all outputs 0).
  - Any pending write-capture state is cleared.
  - Reset has priority over everything, including a write in progress.
- Write qualification: wq = (_ENA==0) && (R_W==0) && (_DS==0), evaluated on sampled inputs.
- Capture:
  - Each clock with wq=1, a shadow register cap <= DIN and flag pend <= 1.
  - The last value sampled before strobe release wins.
- Commit:
  - On the first clock where _DS is sampled 1 while pend=1, register <= cap and pend <= 0.
  - The new value is visible on the outputs one clock after that edge.
- Abort: if _ENA or R_W deasserts while _DS is still 0, pend <= 0 and no commit occurs.
- Writes with _ENA=1, or with R_W=1, never modify the register.
- Bit map:
  - TCEN=reg[5], PREST=reg[4], PDMD=reg[3], INTEN=reg[2], DDIR=reg[1], IO_DX=reg[0].
  - The bit outputs are driven directly from flops; no combinational path from inputs.
- Read: DOUT = reg when _ENA=0 && R_W=1 && _DS=0 (combinational on live inputs); otherwise DOUT = 6'b000000.
- A read never alters state.
- Back-to-back writes: a new wq after a commit starts a fresh capture; at most one commit per strobe.
- Unknown/X on DIN outside the capture window has no effect.

Optional Feature:
CTRL_REG_SYNC_EN
- Defined:
  - _ENA, _DS and R_W each pass through a 2-flop synchronizer to SCLK before qualification.
  - DIN is captured from the same synchronized timing.
  - Write commit latency becomes 3 clocks after _DS rises.
  - The DOUT read gating uses the synchronized signals.
- Undefined: inputs are used directly as sampled on SCLK.
- Register contents after a completed write are identical either way.

Decomposition:
- Shared package sdmac_pkg holds:
  - CNTR bit-index constants (CNTR_TCEN=5 … CNTR_IO_DX=0).
  - CNTR width and reset-value constant.
- One natural sub-module, sdmac_strobe_sync:
  - Optional synchronizer plus _DS rising-edge detect.
  - Produces the wq and commit pulses.

Test Plan:
- Reset: _RST=0 for one clock with prior reg=6'b111111 -> all bit outputs 0 and DOUT=0 during a subsequent read.
- Write: R_W=0, _ENA=0, _DS low, DIN=6'b010101, then _DS high -> next clock PREST=1, INTEN=1, IO_DX=1, TCEN=0, PDMD=0, DDIR=0.
- Read-back: after the write, R_W=1, _ENA=0, _DS=0 -> DOUT=6'b010101; with _DS=1 or _ENA=1 -> DOUT=0.
- Unselected/read strobe: R_W=1 (or _ENA=1) with DIN=6'b101010 and a full _DS pulse -> register unchanged at 6'b010101.
- Reset mid-write: DIN=6'b111111 captured, _RST=0 asserted before _DS rises -> register 0 and no commit when _DS later rises.
- Abort: _ENA deasserts while _DS=0 during a write of 6'b100000 -> TCEN stays 0.
